// File: rtl/mux2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux2_rr_arbiter
//
// Purpose:
//   Merges two valid/ready requesters (A and B) into a single registered
//   output stage. When both requesters are valid, a round-robin rule
//   alternates between them. The output register reloads in the same cycle
//   it is drained, so the sustained throughput is one word per cycle.
//
// Ports:
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   a_valid     requester A offers a_data
//   a_data      requester A payload
//   a_ready     A's word is taken this cycle (combinational)
//   b_valid     requester B offers b_data
//   b_data      requester B payload
//   b_ready     B's word is taken this cycle (combinational)
//   out_valid   out_data holds a valid word
//   out_data    registered selected payload
//   out_src     source of out_data, 0 = A, 1 = B
//   out_ready   consumer accepts out_data
//   sel         combinational select for this cycle, 0 = A, 1 = B
//               (meaningful only while a_ready or b_ready is high)
//   xfer_count  number of completed output transfers, wraps at 256
// ---------------------------------------------------------------------------
module mux2_rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic [7:0]       xfer_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             src_reg, src_next;
  logic             last_grant_reg, last_grant_next;
  logic [7:0]       count_reg, count_next;

  logic             can_load;
  logic             grant_a;
  logic             grant_b;
  logic             out_fire;
  logic [WIDTH-1:0] sel_data;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  // The output register can accept a new word when it is empty or when its
  // current word leaves this cycle. Gating with rst_n keeps both readies low
  // while reset is asserted, so no requester believes it was served by a
  // cycle that the reset is about to discard.
  always_comb begin
    can_load = rst_n && ((state_reg == EMPTY) || out_ready);
  end

  // last_grant_reg = 1 means B was served last, so A wins a contested cycle.
  // The two grant terms are mutually exclusive by construction: when both
  // requesters are valid exactly one of (last_grant_reg, !last_grant_reg)
  // is true.
  always_comb begin
    grant_a = can_load && a_valid && (!b_valid ||  last_grant_reg);
    grant_b = can_load && b_valid && (!a_valid || !last_grant_reg);
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign sel     = grant_b;

  // A word leaves the output stage only when one is actually held; out_ready
  // while empty has no effect on state or on the transfer counter.
  assign out_fire = (state_reg == FULL) && out_ready;

  // Per-bit 2:1 data select driven by the grant.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data_mux
      assign sel_data[gi] = grant_b ? b_data[gi] : a_data[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    src_next        = src_reg;
    last_grant_next = last_grant_reg;
    count_next      = count_reg + {7'd0, out_fire};

    if (grant_a || grant_b) begin
      // Load (or same-cycle reload while draining): no bubble between words.
      state_next      = FULL;
      data_next       = sel_data;
      src_next        = grant_b;
      last_grant_next = grant_b;
    end else if (out_fire) begin
      // Drained with nothing to replace it. The stale payload is left in
      // place; out_valid low marks it as meaningless.
      state_next = EMPTY;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      data_reg       <= '0;
      src_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
      count_reg      <= 8'd0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      src_reg        <= src_next;
      last_grant_reg <= last_grant_next;
      count_reg      <= count_next;
    end
  end

  assign out_valid  = (state_reg == FULL);
  assign out_data   = data_reg;
  assign out_src    = src_reg;
  assign xfer_count = count_reg;

endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, data width of both requester ports and the output port.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: a_valid  input  1  requester A offers a_data.
REQ-005 Port: a_data  input  WIDTH  requester A payload.
REQ-006 Port: a_ready  output  1  A's word is taken this cycle.
REQ-007 Port: b_valid  input  1  requester B offers b_data.
REQ-008 Port: b_data  input  WIDTH  requester B payload.
REQ-009 Port: b_ready  output  1  B's word is taken this cycle.
REQ-010 Port: out_valid  output  1  out_data holds a valid word.
REQ-011 Port: out_data  output  WIDTH  registered selected payload.
REQ-012 Port: out_src  output  1  source of out_data, 0 = A, 1 = B.
REQ-013 Port: out_ready  input  1  consumer accepts out_data.
REQ-014 Port: sel  output  1  combinational 2:1 select for this cycle, 0 = A, 1 = B; valid only when a_ready or b_ready is high.
REQ-015 Port: xfer_count  output  8  count of completed output transfers.

Function
REQ-016 Two states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
REQ-017 can_load = (state == EMPTY) or out_ready.
REQ-018 Arbitration when can_load:
- only a_valid: grant A.
- only b_valid: grant B.
- both valid: grant the requester not granted last (round-robin on last_grant).
- neither valid: no grant.
REQ-019 Ready and select:
- a_ready = can_load and grant A; b_ready = can_load and grant B.
- Never both high in one cycle.
- Both combinational; neither depends on a_valid/b_valid of the other requester beyond REQ-018.
REQ-020 Load on a grant: next edge captures the selected data into out_data, out_src = sel, last_grant = sel, state = FULL.
REQ-021 Transitions:
- EMPTY, no grant: stays EMPTY.
- FULL, out_ready = 0: holds out_data and out_src unchanged; a_ready = b_ready = 0.
- FULL, out_ready = 1, no grant: goes to EMPTY.
- FULL, out_ready = 1, grant: reloads same cycle, stays FULL; back-to-back, no bubble.
REQ-022 Latency: accepted word appears on out_data the cycle after its ready handshake; sustained throughput 1 word/cycle.
REQ-023 xfer_count increments by 1 on each edge with out_valid and out_ready both high; wraps 255 -> 0.
REQ-024 last_grant changes only on a grant; a requester held off by out_ready = 0 keeps its turn.
REQ-025 out_ready while EMPTY is ignored for counting and state.

Reset
REQ-026 While rst_n = 0 at a rising edge:
- state = EMPTY, out_valid = 0, out_data = 0, out_src = 0, xfer_count = 0.
- last_grant = 1, so A wins the first contested cycle.
REQ-027 During reset, a_ready = 0 and b_ready = 0 regardless of inputs.
REQ-028 Reset mid-transfer discards the held word without counting it; the first grant after release follows REQ-026.

Verification
REQ-029 After reset, a_valid = b_valid = 1, a_data = 4'h3, b_data = 4'hC, out_ready = 1 held -> out_data sequence 3, C, 3, C; out_src 0, 1, 0, 1; one word per cycle.
REQ-030 Only b_valid = 1, b_data = 4'h5, out_ready = 0 -> cycle 1: b_ready = 1; then out_valid = 1, out_data = 5, b_ready = 0; out_data holds 5 until out_ready = 1; xfer_count increments once.
REQ-031 FULL with out_src = 0, both valid, out_ready = 0 for 3 cycles, then 1 -> no ready during stall; on release B is granted first (b_ready = 1) and out_data loads b_data the next edge.
REQ-032 256 transfers from A alone with out_ready = 1 -> xfer_count reads 0 after the 256th and 1 after the 257th.
REQ-033 rst_n = 0 for one edge while FULL with out_data = 4'hA -> out_valid = 0, out_data = 0, xfer_count = 0; next contested grant goes to A.
REQ-034 Random valid/out_ready stimulus, 10k cycles -> every a/b word accepted exactly once, in per-source order; a_ready and b_ready never both high; no contested-cycle starvation beyond one grant.
